// File: rtl/zircon_avalon_ps2_mouse_ctrl_if.sv
// Signal bundle between the PS/2 mouse controller, its byte transceiver and the Avalon side.
// The slave modport is the controller's view; master is the environment's view.
interface zircon_avalon_ps2_mouse_ctrl_if;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_error;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       avs_read;
  logic       left_button;
  logic       right_button;
  logic       middle_button;
  logic [8:0] x_increment;
  logic [8:0] y_increment;
  logic       ins_interrupt;
  logic       init_done;

  modport slave (
    input  tx_ready, tx_error, rx_valid, rx_data, rx_error, avs_read,
    output tx_valid, tx_data, left_button, right_button, middle_button,
           x_increment, y_increment, ins_interrupt, init_done
  );

  modport master (
    output tx_ready, tx_error, rx_valid, rx_data, rx_error, avs_read,
    input  tx_valid, tx_data, left_button, right_button, middle_button,
           x_increment, y_increment, ins_interrupt, init_done
  );
endinterface

// File: rtl/zircon_avalon_ps2_mouse_ctrl.sv
// PS/2 mouse controller: reset/enable init sequence with retries, then 3-byte stream packet decode.
// Optional macro PS2_MOUSE_OVF_CLAMP_EN clamps X/Y to full scale when the overflow bits are set.
module zircon_avalon_ps2_mouse_ctrl #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned TIMEOUT_MS = 500,
  parameter int unsigned MAX_RETRY  = 3
) (
  input logic                           csi_clk,
  input logic                           rsi_reset_n,
  zircon_avalon_ps2_mouse_ctrl_if.slave bus_io
);

  localparam int unsigned TMO_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int unsigned TMR_W   = $clog2(TMO_CYC + 1);
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 1);
  localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(TMO_CYC);
  localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_CMD,
    WAIT_ACK1,
    WAIT_BAT,
    WAIT_ID,
    ENABLE_CMD,
    WAIT_ACK2,
    STREAM,
    ERROR
  } state_e;

  state_e           state_q;
  logic [RTY_W-1:0] retry_q;
  logic [1:0]       idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic [7:0]       b0_q;
  logic [7:0]       b1_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic             left_q;
  logic             right_q;
  logic             middle_q;
  logic [8:0]       x_q;
  logic [8:0]       y_q;
  logic             irq_q;
  logic             init_done_q;

  logic             timeout_d;
  logic             is_cmd_d;
  logic             is_wait_d;
  logic [7:0]       exp_byte_d;
  state_e           adv_state_d;
  logic             fail_d;
  logic             match_d;
  logic [RTY_W-1:0] retry_d;
  logic             go_error_d;
  logic             pkt_done_d;
  logic [8:0]       x_d;
  logic [8:0]       y_d;

  // Expected response per wait state and the failure/advance decisions of the init sequence.
  always_comb begin
    timeout_d   = (tmr_q >= TMO_LIM);
    is_cmd_d    = (state_q == RESET_CMD) || (state_q == ENABLE_CMD);
    is_wait_d   = 1'b0;
    exp_byte_d  = 8'h00;
    adv_state_d = state_q;
    case (state_q)
      WAIT_ACK1: begin is_wait_d = 1'b1; exp_byte_d = 8'hFA; adv_state_d = WAIT_BAT;   end
      WAIT_BAT:  begin is_wait_d = 1'b1; exp_byte_d = 8'hAA; adv_state_d = WAIT_ID;    end
      WAIT_ID:   begin is_wait_d = 1'b1; exp_byte_d = 8'h00; adv_state_d = ENABLE_CMD; end
      WAIT_ACK2: begin is_wait_d = 1'b1; exp_byte_d = 8'hFA; adv_state_d = STREAM;     end
      default:   ;
    endcase
    fail_d     = (is_cmd_d || is_wait_d) &&
                 (bus_io.rx_error || bus_io.tx_error || timeout_d ||
                  (is_wait_d && bus_io.rx_valid && (bus_io.rx_data != exp_byte_d)));
    match_d    = is_wait_d && bus_io.rx_valid && (bus_io.rx_data == exp_byte_d);
    retry_d    = retry_q + 1'b1;
    go_error_d = (retry_d >= RTY_LIM);
    pkt_done_d = (state_q == STREAM) && (idx_q == 2'd2) &&
                 bus_io.rx_valid && !bus_io.rx_error;
  end

  // Packet fields assembled from the two stored bytes plus the byte arriving now.
  always_comb begin
    x_d = {b0_q[4], b1_q};
    y_d = {b0_q[5], bus_io.rx_data};
`ifdef PS2_MOUSE_OVF_CLAMP_EN
    if (b0_q[6]) x_d = b0_q[4] ? 9'h100 : 9'h0FF;
    if (b0_q[7]) y_d = b0_q[5] ? 9'h100 : 9'h0FF;
`endif
  end

`ifdef PS2_MOUSE_OVF_CLAMP_EN
  logic unused_b0;
  assign unused_b0 = b0_q[3];
`else
  logic unused_b0;
  assign unused_b0 = ^{b0_q[7:6], b0_q[3]};
`endif

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q     <= RESET_CMD;
      retry_q     <= '0;
      idx_q       <= 2'd0;
      tmr_q       <= '0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      middle_q    <= 1'b0;
      x_q         <= 9'h000;
      y_q         <= 9'h000;
      irq_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      irq_q <= pkt_done_d | (irq_q & ~bus_io.avs_read);
      case (state_q)
        RESET_CMD, ENABLE_CMD: begin
          tmr_q <= tmr_q + 1'b1;
          if (fail_d) begin
            retry_q    <= retry_d;
            tx_valid_q <= 1'b0;
            tmr_q      <= '0;
            state_q    <= go_error_d ? ERROR : RESET_CMD;
          end else if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= (state_q == RESET_CMD) ? 8'hFF : 8'hF4;
          end else if (bus_io.tx_ready) begin
            tx_valid_q <= 1'b0;
            tmr_q      <= '0;
            state_q    <= (state_q == RESET_CMD) ? WAIT_ACK1 : WAIT_ACK2;
          end
        end

        WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
          tmr_q <= bus_io.rx_valid ? '0 : tmr_q + 1'b1;
          if (fail_d) begin
            retry_q <= retry_d;
            tmr_q   <= '0;
            state_q <= go_error_d ? ERROR : RESET_CMD;
          end else if (match_d) begin
            tmr_q   <= '0;
            state_q <= adv_state_d;
            if (state_q == WAIT_ACK2) init_done_q <= 1'b1;
          end
        end

        STREAM: begin
          // The timer only runs while a packet is partially received.
          if (idx_q == 2'd0 || bus_io.rx_valid) tmr_q <= '0;
          else                                  tmr_q <= tmr_q + 1'b1;
          if ((bus_io.rx_error || timeout_d) && idx_q != 2'd0) begin
            idx_q <= 2'd0;
            tmr_q <= '0;
          end else if (bus_io.rx_valid && !bus_io.rx_error) begin
            case (idx_q)
              2'd0: begin
                if (bus_io.rx_data[3]) begin
                  b0_q  <= bus_io.rx_data;
                  idx_q <= 2'd1;
                end
              end
              2'd1: begin
                b1_q  <= bus_io.rx_data;
                idx_q <= 2'd2;
              end
              2'd2: begin
                left_q   <= b0_q[0];
                right_q  <= b0_q[1];
                middle_q <= b0_q[2];
                x_q      <= x_d;
                y_q      <= y_d;
                idx_q    <= 2'd0;
              end
              default: idx_q <= 2'd0;
            endcase
          end
        end

        default: begin
          tx_valid_q <= 1'b0;
          tmr_q      <= '0;
        end
      endcase
    end
  end

  assign bus_io.tx_valid      = tx_valid_q;
  assign bus_io.tx_data       = tx_data_q;
  assign bus_io.left_button   = left_q;
  assign bus_io.right_button  = right_q;
  assign bus_io.middle_button = middle_q;
  assign bus_io.x_increment   = x_q;
  assign bus_io.y_increment   = y_q;
  assign bus_io.ins_interrupt = irq_q;
  assign bus_io.init_done     = init_done_q;

endmodule
